// File: rtl/nrisc_pkg.sv
// rtl/nrisc_pkg.sv - shared encodings for the nrisc control FSM and its decoder
package nrisc_pkg;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_HALT  = 3'd3,
        S_WAIT  = 3'd4,
        S_IRQ   = 3'd5
    } state_t;

    localparam logic [3:0] OP_SYS = 4'h0, OP_LW  = 4'h1, OP_SW  = 4'h2, OP_LI  = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4, OP_JZ  = 4'h5, OP_JC  = 4'h6, OP_JM  = 4'h7;
    localparam logic [3:0] OP_ADD = 4'h8, OP_SUB = 4'h9, OP_AND = 4'hA, OP_OR  = 4'hB;
    localparam logic [3:0] OP_XOR = 4'hC, OP_SHR = 4'hD, OP_SHL = 4'hE, OP_EXT = 4'hF;

    localparam logic [3:0] SUB_NOP  = 4'd0, SUB_HALT = 4'd1, SUB_WAIT = 4'd2, SUB_WAIT2 = 4'd3;
    localparam logic [3:0] SUB_CALL = 4'd4, SUB_RET  = 4'd5, SUB_RETI = 4'd6;
    localparam logic [3:0] SUB_EI   = 4'd7, SUB_DI   = 4'd8;

    localparam logic [3:0] ULA_ADD = 4'd0, ULA_SUB = 4'd1, ULA_AND = 4'd2, ULA_OR  = 4'd3;
    localparam logic [3:0] ULA_XOR = 4'd4, ULA_SHR = 4'd5, ULA_SHL = 4'd6, ULA_NOT = 4'd7;

    // Extended ALU op selector, taken from rf2[1:0]
    localparam logic [1:0] EXT_NOT = 2'd0, EXT_NOP = 2'd1, EXT_INC = 2'd2, EXT_DEC = 2'd3;

    localparam logic [1:0] PC_INC = 2'd0, PC_ULA = 2'd1, PC_STACK = 2'd2, PC_VECTOR = 2'd3;
    localparam logic [1:0] STK_NONE = 2'd0, STK_PUSH = 2'd1, STK_POP = 2'd2;

    // Flags arrive as {C, Z, M}
    function automatic logic branch_taken(input logic [3:0] op, input logic [2:0] flags);
        case (op)
            OP_JZ:   return flags[1];
            OP_JC:   return flags[2];
            OP_JM:   return flags[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/nrisc_ctrl_decode.sv
// rtl/nrisc_ctrl_decode.sv - combinational control-word decode from state and IR
module nrisc_ctrl_decode
    import nrisc_pkg::*;
#(
    parameter int RA_W = 4
) (
    input  state_t               state,
    input  logic [4+3*RA_W-1:0]  ir,
    input  logic [2:0]           ula_flags,
    input  logic                 mem_ack,
    input  logic                 irq,
    input  logic                 ie,
    input  logic                 stack_full,
    input  logic                 stack_empty,
    output logic [3:0]           ula_ctrl,
    output logic                 ula_incdec,
    output logic [RA_W-1:0]      reg_rd,
    output logic [RA_W-1:0]      reg_rf1,
    output logic [RA_W-1:0]      reg_rf2,
    output logic                 reg_we,
    output logic                 imm_sel,
    output logic                 data_sel,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 pc_en,
    output logic [1:0]           pc_ctrl,
    output logic [1:0]           stack_ctrl,
    output logic                 irq_ack
);
    localparam int INSTR_W = 4 + 3*RA_W;

    logic [3:0]      op;
    logic [3:0]      sub;
    logic [RA_W-1:0] rd, rf1, rf2;

    assign op  = ir[INSTR_W-1 -: 4];
    assign rd  = ir[3*RA_W-1 -: RA_W];
    assign rf1 = ir[2*RA_W-1 -: RA_W];
    assign rf2 = ir[RA_W-1:0];
    assign sub = ir[2*RA_W +: 4];

    always_comb begin
        ula_ctrl   = ULA_ADD;
        ula_incdec = 1'b0;
        reg_rd     = '0;
        reg_rf1    = '0;
        reg_rf2    = '0;
        reg_we     = 1'b0;
        imm_sel    = 1'b0;
        data_sel   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        pc_en      = 1'b0;
        pc_ctrl    = PC_INC;
        stack_ctrl = STK_NONE;
        irq_ack    = 1'b0;
        case (state)
            S_EXEC: begin
                reg_rd  = rd;
                reg_rf1 = rf1;
                reg_rf2 = rf2;
                case (op)
                    OP_SYS: begin
                        case (sub)
                            SUB_HALT, SUB_WAIT, SUB_WAIT2: ;
                            SUB_CALL: if (!stack_full) begin
                                stack_ctrl = STK_PUSH;
                                pc_en      = 1'b1;
                                pc_ctrl    = PC_ULA;
                            end
                            SUB_RET, SUB_RETI: if (!stack_empty) begin
                                stack_ctrl = STK_POP;
                                pc_en      = 1'b1;
                                pc_ctrl    = PC_STACK;
                            end
                            default: pc_en = 1'b1;
                        endcase
                    end
                    OP_LW, OP_SW: ;
                    OP_LI: begin
                        imm_sel = 1'b1;
                        reg_we  = 1'b1;
                        pc_en   = 1'b1;
                    end
                    OP_JMP: begin
                        pc_en   = 1'b1;
                        pc_ctrl = PC_ULA;
                    end
                    OP_JZ, OP_JC, OP_JM: begin
                        pc_en   = 1'b1;
                        pc_ctrl = branch_taken(op, ula_flags) ? PC_ULA : PC_INC;
                    end
                    default: begin
                        pc_en  = 1'b1;
                        reg_we = 1'b1;
                        case (op)
                            OP_SUB: ula_ctrl = ULA_SUB;
                            OP_AND: ula_ctrl = ULA_AND;
                            OP_OR:  ula_ctrl = ULA_OR;
                            OP_XOR: ula_ctrl = ULA_XOR;
                            OP_SHR: ula_ctrl = {ir[0], ULA_SHR[2:0]};
                            OP_SHL: ula_ctrl = {ir[0], ULA_SHL[2:0]};
                            OP_EXT: begin
                                case (rf2[1:0])
                                    EXT_NOT: ula_ctrl = ULA_NOT;
                                    EXT_INC: ula_incdec = 1'b1;
                                    EXT_DEC: begin
                                        ula_ctrl   = ULA_SUB;
                                        ula_incdec = 1'b1;
                                    end
                                    default: reg_we = 1'b0;
                                endcase
                            end
                            default: ula_ctrl = ULA_ADD;
                        endcase
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                reg_rd  = rd;
                reg_rf1 = rf1;
                reg_rf2 = rf2;
                if (mem_ack) begin
                    pc_en = 1'b1;
                    if (op == OP_SW) begin
                        // Store data is read through the ALU as rd AND rd
                        mem_we   = 1'b1;
                        ula_ctrl = ULA_AND;
                        reg_rf1  = rd;
                        reg_rf2  = rd;
                    end else begin
                        reg_we   = 1'b1;
                        data_sel = 1'b1;
                    end
                end
            end
            S_WAIT: if (irq && !ie) pc_en = 1'b1;
            S_IRQ: if (!stack_full) begin
                stack_ctrl = STK_PUSH;
                pc_en      = 1'b1;
                pc_ctrl    = PC_VECTOR;
                irq_ack    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/nrisc_ctrl_fsm.sv
// rtl/nrisc_ctrl_fsm.sv - nrisc control FSM: state, IR, interrupt enable, return-stack depth, MEM timeout
module nrisc_ctrl_fsm
    import nrisc_pkg::*;
#(
    parameter  int RA_W        = 4,
    parameter  int STACK_DEPTH = 8,
    parameter  int MEM_TIMEOUT = 15,
    localparam int INSTR_W     = 4 + 3*RA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_valid,
    input  logic [2:0]         ula_flags,
    input  logic               irq,
    input  logic               mem_ack,
    output logic [3:0]         ula_ctrl,
    output logic               ula_incdec,
    output logic [RA_W-1:0]    reg_rd,
    output logic [RA_W-1:0]    reg_rf1,
    output logic [RA_W-1:0]    reg_rf2,
    output logic               reg_we,
    output logic               imm_sel,
    output logic               data_sel,
    output logic               mem_req,
    output logic               mem_we,
    output logic               pc_en,
    output logic [1:0]         pc_ctrl,
    output logic [1:0]         stack_ctrl,
    output logic [2:0]         state,
    output logic               halted,
    output logic               irq_ack,
    output logic               err
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int TW  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [SPW-1:0] SP_MAX = SPW'(STACK_DEPTH);
    localparam logic [TW-1:0]  T_LAST = TW'(MEM_TIMEOUT - 1);

    state_t             state_q;
    logic [INSTR_W-1:0] ir;
    logic               ie;
    logic               err_q;
    logic [SPW-1:0]     sp;
    logic [TW-1:0]      tcnt;
    logic [3:0]         op;
    logic [3:0]         sub;
    logic               stack_full;
    logic               stack_empty;

    assign op          = ir[INSTR_W-1 -: 4];
    assign sub         = ir[2*RA_W +: 4];
    assign stack_full  = (sp == SP_MAX);
    assign stack_empty = (sp == '0);
    assign state       = state_q;
    assign halted      = (state_q == S_HALT);
    assign err         = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir      <= '0;
            ie      <= 1'b0;
            sp      <= '0;
            err_q   <= 1'b0;
            tcnt    <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (irq && ie) begin
                        state_q <= S_IRQ;
                    end else if (instr_valid) begin
                        ir      <= instr_in;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_q <= S_FETCH;
                    case (op)
                        OP_SYS: begin
                            case (sub)
                                SUB_HALT:            state_q <= S_HALT;
                                SUB_WAIT, SUB_WAIT2: state_q <= S_WAIT;
                                SUB_CALL: begin
                                    if (stack_full) begin
                                        err_q   <= 1'b1;
                                        state_q <= S_HALT;
                                    end else begin
                                        sp <= sp + SPW'(1);
                                    end
                                end
                                SUB_RET, SUB_RETI: begin
                                    if (stack_empty) begin
                                        err_q   <= 1'b1;
                                        state_q <= S_HALT;
                                    end else begin
                                        sp <= sp - SPW'(1);
                                        if (sub == SUB_RETI) ie <= 1'b1;
                                    end
                                end
                                SUB_EI:  ie <= 1'b1;
                                SUB_DI:  ie <= 1'b0;
                                default: ;
                            endcase
                        end
                        OP_LW, OP_SW: begin
                            state_q <= S_MEM;
                            tcnt    <= '0;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    // An ack on the last allowed cycle still completes the access
                    if (mem_ack) begin
                        state_q <= S_FETCH;
                    end else if (tcnt == T_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_WAIT: if (irq) state_q <= ie ? S_IRQ : S_FETCH;
                S_IRQ: begin
                    if (stack_full) begin
                        err_q   <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        sp      <= sp + SPW'(1);
                        ie      <= 1'b0;
                        state_q <= S_FETCH;
                    end
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    nrisc_ctrl_decode #(.RA_W(RA_W)) u_decode (
        .state       (state_q),
        .ir          (ir),
        .ula_flags   (ula_flags),
        .mem_ack     (mem_ack),
        .irq         (irq),
        .ie          (ie),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ula_ctrl    (ula_ctrl),
        .ula_incdec  (ula_incdec),
        .reg_rd      (reg_rd),
        .reg_rf1     (reg_rf1),
        .reg_rf2     (reg_rf2),
        .reg_we      (reg_we),
        .imm_sel     (imm_sel),
        .data_sel    (data_sel),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .pc_en       (pc_en),
        .pc_ctrl     (pc_ctrl),
        .stack_ctrl  (stack_ctrl),
        .irq_ack     (irq_ack)
    );

endmodule

// File: tb/tb_nrisc_ctrl_fsm.sv
// tb/tb_nrisc_ctrl_fsm.sv - randomized scoreboard bench for nrisc_ctrl_fsm
module tb_nrisc_ctrl_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr_in = '0;
    logic        instr_valid = 1'b0;
    logic [2:0]  ula_flags = '0;
    logic        irq = 1'b0;
    logic        mem_ack = 1'b0;
    logic [3:0]  ula_ctrl;
    logic        ula_incdec;
    logic [3:0]  reg_rd, reg_rf1, reg_rf2;
    logic        reg_we, imm_sel, data_sel, mem_req, mem_we, pc_en;
    logic [1:0]  pc_ctrl, stack_ctrl;
    logic [2:0]  state;
    logic        halted, irq_ack, err;

    nrisc_ctrl_fsm dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
        .ula_flags(ula_flags), .irq(irq), .mem_ack(mem_ack),
        .ula_ctrl(ula_ctrl), .ula_incdec(ula_incdec), .reg_rd(reg_rd),
        .reg_rf1(reg_rf1), .reg_rf2(reg_rf2), .reg_we(reg_we), .imm_sel(imm_sel),
        .data_sel(data_sel), .mem_req(mem_req), .mem_we(mem_we), .pc_en(pc_en),
        .pc_ctrl(pc_ctrl), .stack_ctrl(stack_ctrl), .state(state), .halted(halted),
        .irq_ack(irq_ack), .err(err)
    );

    always #5 clk = ~clk;

    wire [32:0] all_out = {ula_ctrl, ula_incdec, reg_rd, reg_rf1, reg_rf2, reg_we, imm_sel,
                           data_sel, mem_req, mem_we, pc_en, pc_ctrl, stack_ctrl, state,
                           halted, irq_ack, err};

    // One record per cycle in which any strobe fires
    typedef struct packed {
        logic [3:0] ula;
        logic       inc;
        logic [3:0] rd;
        logic [3:0] f1;
        logic [3:0] f2;
        logic       pen, we, imm, dsel, mwe;
        logic [1:0] pcc;
        logic [1:0] stk;
        logic       ack;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_sp = 0;
    bit   m_ie = 1'b0;
    bit   mem_en = 1'b1;
    int   fixed_delay = -1;
    int   mem_wait = 0;
    int   alu_tab[7] = '{0, 1, 2, 3, 4, 5, 6};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: acks after mem_wait request cycles
    always begin
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (mem_req && mem_en) begin
            if (mem_wait == 0) mem_ack = 1'b1;
            else mem_wait--;
        end else if (!mem_req) begin
            mem_wait = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
        end
    end

    // Monitor
    always @(negedge clk) begin
        rec_t a;
        if (!rst && (pc_en || reg_we || mem_we || irq_ack || stack_ctrl != 2'd0)) begin
            a = {ula_ctrl, ula_incdec, reg_rd, reg_rf1, reg_rf2, pc_en, reg_we, imm_sel,
                 data_sel, mem_we, pc_ctrl, stack_ctrl, irq_ack};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got %0h expected none", a);
            end else begin
                chk("strobe", 64'(a), 64'(exp_q.pop_front()));
            end
        end
    end

    function automatic rec_t base(input logic [15:0] i);
        rec_t r = '0;
        r.rd  = i[11:8];
        r.f1  = i[7:4];
        r.f2  = i[3:0];
        r.pen = 1'b1;
        return r;
    endfunction

    function automatic rec_t irq_rec();
        rec_t r = '0;
        r.pen = 1'b1;
        r.pcc = 2'd3;
        r.stk = 2'd1;
        r.ack = 1'b1;
        return r;
    endfunction

    task automatic model(input logic [15:0] i, input logic [2:0] fl);
        rec_t r;
        int   op, sub;
        op  = int'(i[15:12]);
        sub = int'(i[11:8]);
        r   = base(i);
        case (op)
            0: case (sub)
                1, 2, 3: ;
                4: if (m_sp < 8) begin r.stk = 2'd1; r.pcc = 2'd1; m_sp++; exp_q.push_back(r); end
                5, 6: if (m_sp > 0) begin
                    r.stk = 2'd2; r.pcc = 2'd2; m_sp--;
                    if (sub == 6) m_ie = 1'b1;
                    exp_q.push_back(r);
                end
                7: begin m_ie = 1'b1; exp_q.push_back(r); end
                8: begin m_ie = 1'b0; exp_q.push_back(r); end
                default: exp_q.push_back(r);
            endcase
            1: if (mem_en) begin r.we = 1'b1; r.dsel = 1'b1; exp_q.push_back(r); end
            2: if (mem_en) begin
                r.f1 = i[11:8]; r.f2 = i[11:8]; r.ula = 4'd2; r.mwe = 1'b1;
                exp_q.push_back(r);
            end
            3: begin r.we = 1'b1; r.imm = 1'b1; exp_q.push_back(r); end
            4: begin r.pcc = 2'd1; exp_q.push_back(r); end
            5: begin r.pcc = {1'b0, fl[1]}; exp_q.push_back(r); end
            6: begin r.pcc = {1'b0, fl[2]}; exp_q.push_back(r); end
            7: begin r.pcc = {1'b0, fl[0]}; exp_q.push_back(r); end
            15: begin
                case (i[1:0])
                    2'd0: begin r.ula = 4'd7; r.we = 1'b1; end
                    2'd1: ;
                    2'd2: begin r.inc = 1'b1; r.we = 1'b1; end
                    default: begin r.ula = 4'd1; r.inc = 1'b1; r.we = 1'b1; end
                endcase
                exp_q.push_back(r);
            end
            default: begin
                r.we  = 1'b1;
                r.ula = 4'(alu_tab[op-8]);
                if (op >= 13) r.ula[3] = i[0];
                exp_q.push_back(r);
            end
        endcase
    endtask

    task automatic issue(input logic [15:0] i, input logic [2:0] fl);
        int n;
        model(i, fl);
        instr_in    = i;
        ula_flags   = fl;
        instr_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (state != 3'd1 && n < 200);
        if (n >= 200) chk("issue_latch_timeout", 64'(state), 64'd1);
        instr_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; instr_valid = 1'b0; irq = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        m_sp = 0;
        m_ie = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] i;
        int subs[9] = '{0, 4, 5, 6, 7, 8, 9, 12, 15};
        int sub;
        i = 16'($urandom);
        if (i[15:12] == 4'h0) begin
            sub = subs[$urandom_range(0, 8)];
            if (sub == 4 && m_sp >= 8) sub = 5;
            if ((sub == 5 || sub == 6) && m_sp == 0) sub = 4;
            i[11:8] = 4'(sub);
        end
        return i;
    endfunction

    task automatic wait_ack(input string name);
        int n = 0;
        while (!irq_ack && n < 40) begin @(negedge clk); n++; end
        chk(name, 64'(irq_ack), 64'd1);
        @(posedge clk); #1;
        irq = 1'b0;
    endtask

    initial begin
        int   n;
        rec_t r;
        repeat (2) @(posedge clk); #1;
        chk("reset_outputs", 64'(all_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_fetch_outputs", 64'(all_out), 64'd0);

        issue(16'h8123, 3'b000);
        issue(16'h5012, 3'b010);
        issue(16'h5012, 3'b000);

        fixed_delay = 3;
        issue(16'h1456, 3'b000);
        n = 0;
        for (int k = 0; k < 40 && state == 3'd2; k++) begin
            @(negedge clk);
            if (state == 3'd2 && mem_req && !mem_ack) n++;
        end
        chk("lw_req_cycles", 64'(n), 64'd3);
        fixed_delay = -1;

        issue(16'h0200, 3'b000);
        repeat (3) @(negedge clk);
        chk("wait_hold", 64'(state), 64'd4);
        r = '0; r.pen = 1'b1;
        exp_q.push_back(r);
        irq = 1'b1;
        n = 0;
        while (state != 3'd0 && n < 20) begin @(posedge clk); #1; n++; end
        chk("wait_exit_fetch", 64'(state), 64'd0);
        irq = 1'b0;

        for (int k = 0; k < 300; k++) issue(rand_instr(), 3'($urandom));

        issue(16'h0100, 3'b000);
        @(negedge clk);
        chk("halt_instr_halted", 64'({halted, err}), 64'b10);
        chk("queue_drained_rand", 64'(exp_q.size()), 64'd0);

        do_reset();
        issue(16'h0700, 3'b000);
        for (int k = 0; k < 8; k++) issue(16'h0412, 3'b000);
        for (int k = 0; k < 8; k++) issue(16'h0500, 3'b000);
        issue(16'h0500, 3'b000);
        @(negedge clk);
        chk("underflow_err_halt", 64'({err, halted}), 64'b11);

        do_reset();
        issue(16'h0700, 3'b000);
        for (int k = 0; k < 9; k++) issue(16'h0412, 3'b000);
        @(negedge clk);
        chk("overflow_err_halt", 64'({err, halted}), 64'b11);
        chk("queue_drained_stack", 64'(exp_q.size()), 64'd0);

        do_reset();
        mem_en = 1'b0;
        issue(16'h1456, 3'b000);
        n = 1;
        for (int k = 0; k < 40 && state == 3'd2; k++) begin
            @(negedge clk);
            @(posedge clk); #1;
            if (state == 3'd2) n++;
        end
        chk("timeout_mem_cycles", 64'(n), 64'd15);
        @(negedge clk);
        chk("timeout_err_halt", 64'({err, halted}), 64'b11);
        mem_en = 1'b1;

        do_reset();
        issue(16'h0700, 3'b000);
        fixed_delay = 3;
        issue(16'h1456, 3'b000);
        irq = 1'b1;
        exp_q.push_back(irq_rec());
        m_sp++;
        m_ie = 1'b0;
        wait_ack("irq_after_lw");
        fixed_delay = -1;
        issue(16'h0600, 3'b000);
        irq = 1'b1;
        exp_q.push_back(irq_rec());
        m_sp++;
        m_ie = 1'b0;
        wait_ack("irq_after_reti");
        repeat (3) @(negedge clk);
        chk("queue_drained_irq", 64'(exp_q.size()), 64'd0);

        do_reset();
        mem_en = 1'b0;
        issue(16'h1456, 3'b000);
        chk("mem_req_before_rst", 64'(mem_req), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_state", 64'(state), 64'd0);
        chk("async_rst_outputs", 64'(all_out), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        mem_en = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 64'(all_out), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nrisc_ctrl_fsm.md
NRISC_CTRL_FSM -- requirements
Module: nrisc_ctrl_fsm

Interface
REQ-001 SHALL have parameter RA_W, default 4: register-address field width.
REQ-002 SHALL have parameter STACK_DEPTH, default 8: return-stack capacity tracked by sp (width clog2(STACK_DEPTH+1)).
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15: max cycles awaiting mem_ack; INSTR_W SHALL be the localparam 4+3*RA_W.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-006 SHALL have ports instr_in  in  INSTR_W: {op[3:0], rd, rf1, rf2}; instr_valid  in  1: instr_in valid.
REQ-007 SHALL have ports ula_flags  in  3: {C,Z,M}; irq  in  1: interrupt request, level; mem_ack  in  1: memory done.
REQ-008 SHALL have ports ula_ctrl  out  4; ula_incdec  out  1; reg_rd/reg_rf1/reg_rf2  out  RA_W each; reg_we  out  1; imm_sel  out  1; data_sel  out  1.
REQ-009 SHALL have ports mem_req  out  1; mem_we  out  1; pc_en  out  1; pc_ctrl  out  2 (0 INC, 1 ULA, 2 STACK, 3 VECTOR); stack_ctrl  out  2 (0 none, 1 push, 2 pop).
REQ-010 SHALL have ports state  out  3; halted  out  1; irq_ack  out  1; err  out  1.

Function
REQ-011 SHALL implement states FETCH, EXEC, MEM, HALT, WAIT, IRQ; outputs SHALL decode from state and the registered IR only.
REQ-012 FETCH: if irq&ie -> IRQ; else if instr_valid, latch IR and -> EXEC; else stay.
REQ-013 EXEC ALU ops (op 8..F) and LI (op 3): reg_we=1, pc_en=1/INC, one cycle, -> FETCH; two cycles per instruction.
REQ-014 ULA codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SHR {IR[0],5}, SHL {IR[0],6}; op F by rf2[1:0]: 0 NOT (7), 2 INC (0, incdec=1), 3 DEC (1, incdec=1), 1 NOP with no reg_we.
REQ-015 LI: imm_sel=1, reg_we=1.
REQ-016 LW/SW (op 1/2) in EXEC: ULA ADD of rf1,rf2 -> MEM; MEM: mem_req=1 held until mem_ack.
REQ-017 MEM on mem_ack: LW reg_we=1, data_sel=1; SW mem_we=1, ula_ctrl=2, rf1=rf2=rd; pc_en INC, -> FETCH.
REQ-018 A MEM cycle counter SHALL start at 0 on MEM entry; at MEM_TIMEOUT without ack: err=1, -> HALT.
REQ-019 JMP op 4: pc_en=1, pc_ctrl=ULA (ADD rf1,rf2); JZ/JC/JM op 5/6/7 SHALL use flag Z/C/M sampled in EXEC; not taken -> pc INC.
REQ-020 System op 0, sub-op rd[3:0]: 0 NOP, 1 HALT, 2/3 WAIT, 4 CALL (push, pc ULA), 5 RET (pop, pc STACK), 6 RETI (RET plus ie=1), 7 EI, 8 DI; undefined -> NOP with pc INC.
REQ-021 sp SHALL increment on push and decrement on pop; push at sp==STACK_DEPTH or pop at sp==0 SHALL suppress stack_ctrl, set err, -> HALT.
REQ-022 IRQ state: push, pc_en=1/VECTOR, ie=0, irq_ack=1, for one cycle, -> FETCH; same overflow rule as REQ-021.
REQ-023 WAIT: hold until irq; -> IRQ if ie else FETCH with pc INC.
REQ-024 HALT: halted=1, no strobes; exit only by rst.
REQ-025 reg_we, pc_en, mem_we, irq_ack, stack_ctrl SHALL be single-cycle strobes; irq raised mid-instruction SHALL be taken only at the next FETCH.

Reset
REQ-026 rst SHALL force state=FETCH, IR=0, ie=0, sp=0, err=0, timeout counter=0, all outputs 0, immediately and asynchronously, from any state.
REQ-027 rst SHALL abort a pending MEM access; mem_req SHALL drop to 0 without waiting for mem_ack.

Structure
REQ-028 Package nrisc_pkg SHALL hold the state encoding, opcode/sub-op constants, ULA codes, and pc_ctrl/stack_ctrl codes.
REQ-029 Combinational decode SHALL sit in sub-module nrisc_ctrl_decode; the FSM, sp, ie and timeout counter SHALL remain in nrisc_ctrl_fsm.

Verification
REQ-030 ADD IR=0x8123: one EXEC cycle with ula_ctrl=0, rd=1, rf1=2, rf2=3, reg_we=1, pc_en=1/INC.
REQ-031 LW 0x1456, mem_ack after 3 cycles: mem_req held 3 cycles, then reg_we=1, data_sel=1; with no ack, err=1 and halted after 15 cycles.
REQ-032 JZ 0x5012: with Z=1 pc_ctrl=1; with Z=0 pc_ctrl=0.
REQ-033 EI, then 8 nested CALLs then a 9th: 9th sets err=1, halted=1, no push; 8 RETs return sp to 0.
REQ-034 irq=1 with ie=1 during LW: IRQ taken after MEM completes; push, pc_ctrl=3, irq_ack for 1 cycle; RETI restores ie=1.
REQ-035 rst asserted mid-MEM: all outputs 0 and state=FETCH immediately, before next clk edge.
